// File: rtl/ram_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ram_master
//
// Single-request bus master for a simple dual-port RAM with a registered read
// port. One request (read or write) is accepted at a time. Writes are issued
// on the RAM write port. Reads are issued on the RAM read port and their
// result is returned on a valid/ready response channel.
//
// Optional feature (macro RAM_MASTER_WRITE_VERIFY_EN):
//   Each write is read back from the RAM and compared with the written data.
//   The first mismatch sets a sticky error flag and records its address.
//   Without the macro the error outputs are constant 0.
//
// Ports
//   Clock                : single clock (RAM write and read clocks tied to it)
//   Reset_n              : asynchronous, active-low reset
//   Req_valid/Req_ready  : request handshake, accepted when both are high
//   Req_write            : 1 = write, 0 = read
//   Req_address/Req_data : request address and write data
//   Rsp_valid/Rsp_ready  : read response handshake
//   Rsp_data             : read response data, stable while Rsp_valid is high
//   Wr_done              : one-cycle pulse when a write completes
//   write_address, Write_Enable, DATA_WRITE : RAM write port
//   read_address, Read_Enable, DATA_READ    : RAM read port (DATA_READ is
//                          registered by the RAM on the edge sampling
//                          Read_Enable high)
//   Verify_error         : sticky write-verify mismatch flag
//   Verify_error_address : address of the first verify mismatch
// -----------------------------------------------------------------------------
module ram_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset_n,

    input  logic                     Req_valid,
    output logic                     Req_ready,
    input  logic                     Req_write,
    input  logic [ADDRESS_WIDTH-1:0] Req_address,
    input  logic [DATA_WIDTH-1:0]    Req_data,

    output logic                     Rsp_valid,
    input  logic                     Rsp_ready,
    output logic [DATA_WIDTH-1:0]    Rsp_data,

    output logic                     Wr_done,

    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic                     Write_Enable,
    output logic [DATA_WIDTH-1:0]    DATA_WRITE,

    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic                     Read_Enable,
    input  logic [DATA_WIDTH-1:0]    DATA_READ,

    output logic                     Verify_error,
    output logic [ADDRESS_WIDTH-1:0] Verify_error_address
);

`ifdef RAM_MASTER_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4,
        VRD  = 3'd5,
        VCMP = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
    } state_t;
`endif

    state_t                     state_reg;
    logic                       req_ready_reg;
    logic                       rsp_valid_reg;
    logic [DATA_WIDTH-1:0]      rsp_data_reg;
    logic                       wr_done_reg;
    logic [ADDRESS_WIDTH-1:0]   write_address_reg;
    logic                       write_enable_reg;
    logic [DATA_WIDTH-1:0]      data_write_reg;
    logic [ADDRESS_WIDTH-1:0]   read_address_reg;
    logic                       read_enable_reg;

`ifdef RAM_MASTER_WRITE_VERIFY_EN
    logic                       verify_error_reg;
    logic [ADDRESS_WIDTH-1:0]   verify_error_address_reg;
`endif

    // All outputs come straight from registers, so the asynchronous reset
    // forces every one of them to 0 immediately.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg         <= IDLE;
            req_ready_reg     <= 1'b0;
            rsp_valid_reg     <= 1'b0;
            rsp_data_reg      <= '0;
            wr_done_reg       <= 1'b0;
            write_address_reg <= '0;
            write_enable_reg  <= 1'b0;
            data_write_reg    <= '0;
            read_address_reg  <= '0;
            read_enable_reg   <= 1'b0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
            verify_error_reg         <= 1'b0;
            verify_error_address_reg <= '0;
`endif
        end else begin
            // Wr_done is a single-cycle pulse unless a state below re-asserts it.
            wr_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Req_ready comes up one cycle after reset release and is
                    // otherwise raised on every transition back into IDLE.
                    req_ready_reg <= 1'b1;
                    if (Req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        if (Req_write) begin
                            // The write-port registers double as the latched
                            // address/data for the optional read-back check.
                            write_address_reg <= Req_address;
                            data_write_reg    <= Req_data;
                            write_enable_reg  <= 1'b1;
                            state_reg         <= WR;
                        end else begin
                            read_address_reg <= Req_address;
                            read_enable_reg  <= 1'b1;
                            state_reg        <= RD;
                        end
                    end
                end

                WR: begin
                    write_enable_reg <= 1'b0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
                    // Read the just-written location back.
                    read_address_reg <= write_address_reg;
                    read_enable_reg  <= 1'b1;
                    state_reg        <= VRD;
`else
                    wr_done_reg   <= 1'b1;
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
`endif
                end

                RD: begin
                    read_enable_reg <= 1'b0;
                    state_reg       <= CAP;
                end

                CAP: begin
                    // RAM output is valid in this cycle (registered read).
                    rsp_data_reg  <= DATA_READ;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RSP;
                end

                RSP: begin
                    if (Rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

`ifdef RAM_MASTER_WRITE_VERIFY_EN
                VRD: begin
                    read_enable_reg <= 1'b0;
                    // Pulse lands in the VCMP cycle.
                    wr_done_reg     <= 1'b1;
                    state_reg       <= VCMP;
                end

                VCMP: begin
                    // Only the first mismatch records an address; the flag is
                    // sticky until reset.
                    if ((DATA_READ != data_write_reg) && !verify_error_reg) begin
                        verify_error_reg         <= 1'b1;
                        verify_error_address_reg <= write_address_reg;
                    end
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
`endif

                default: begin
                    write_enable_reg <= 1'b0;
                    read_enable_reg  <= 1'b0;
                    rsp_valid_reg    <= 1'b0;
                    req_ready_reg    <= 1'b0;
                    state_reg        <= IDLE;
                end
            endcase
        end
    end

    assign Req_ready     = req_ready_reg;
    assign Rsp_valid     = rsp_valid_reg;
    assign Rsp_data      = rsp_data_reg;
    assign Wr_done       = wr_done_reg;
    assign write_address = write_address_reg;
    assign Write_Enable  = write_enable_reg;
    assign DATA_WRITE    = data_write_reg;
    assign read_address  = read_address_reg;
    assign Read_Enable   = read_enable_reg;

`ifdef RAM_MASTER_WRITE_VERIFY_EN
    assign Verify_error         = verify_error_reg;
    assign Verify_error_address = verify_error_address_reg;
`else
    assign Verify_error         = 1'b0;
    assign Verify_error_address = '0;
`endif

endmodule
